rv_timer_tl: RTL and testbench

- TL-UL device on the system crossbar that provides a RISC-V machine timer: a prescaled 64-bit mtime counter, a 64-bit mtimecmp register and a level interrupt.
- Drives the CPU timer_irq_i input, which is currently tied low.
- Attaches to a free device port of the xbar (tl_dev_h2d[2] / tl_dev_d2h[2]).

---
 rtl/rv_timer_tl.sv | 199 +++++++++++++++++++
 tb/tb_rv_timer_tl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_timer_tl.sv
// rv_timer_tl -- RISC-V machine timer exposed as a TL-UL device.
//
// Provides a prescaled 64-bit mtime counter, a 64-bit mtimecmp register and
// a level interrupt (mtime >= mtimecmp) for the CPU timer_irq_i input.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   tl_i          TL-UL request channel from the crossbar
//   tl_o          TL-UL response channel to the crossbar
//   intr_timer_o  registered timer interrupt, level, active-high
//
// Register map (addr[11:0], 32-bit words):
//   0x00 CTRL (bit0 EN)    0x04 PRESCALE    0x08/0x0C MTIME lo/hi
//   0x10/0x14 MTIMECMP lo/hi                0x18 INTR_STATE (RO)

package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module rv_timer_tl
    import tlul_pkg::*;
#(
    parameter int                   PrescaleW     = 16,
    parameter logic [PrescaleW-1:0] ResetPrescale = '0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    intr_timer_o
);

    // Register state
    logic                 en_q;
    logic [PrescaleW-1:0] presc_q;
    logic [PrescaleW-1:0] pcnt_q;
    logic [63:0]          mtime_q;
    logic [63:0]          mtimecmp_q;
    logic                 intr_q;

    // Response state
    logic        d_valid_q;
    logic [2:0]  d_opcode_q;
    logic [1:0]  d_size_q;
    logic [7:0]  d_source_q;
    logic [31:0] d_data_q;
    logic        d_error_q;

    // Request decode
    logic        acc;
    logic [11:0] off;
    logic [2:0]  idx;
    logic        is_get;
    logic        is_put;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] presc_ext;
    logic        tick;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        end
        return r;
    endfunction

    assign acc    = tl_i.a_valid && !d_valid_q;
    assign off    = tl_i.a_address[11:0];
    assign idx    = off[4:2];
    assign is_get = (tl_i.a_opcode == Get);
    assign is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    // INTR_STATE is read-only, so a write there is an error rather than a no-op.
    assign err    = (off[1:0] != 2'b00) || (off >= 12'h01C) || !(is_get || is_put)
                  || (is_put && (off == 12'h018));
    assign wr     = acc && is_put && !err;

    assign presc_ext = 32'(presc_q);

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = {31'b0, en_q};
            3'd1:    rdata = presc_ext;
            3'd2:    rdata = mtime_q[31:0];
            3'd3:    rdata = mtime_q[63:32];
            3'd4:    rdata = mtimecmp_q[31:0];
            3'd5:    rdata = mtimecmp_q[63:32];
            3'd6:    rdata = {31'b0, intr_q};
            default: rdata = '0;
        endcase
    end

    // rdata is the current value of the addressed register, so merging into
    // it yields the byte-masked write value for every register alike.
    assign wdata = merge(rdata, tl_i.a_data, tl_i.a_mask);

    assign tick = en_q && (pcnt_q == presc_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            presc_q    <= ResetPrescale;
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            intr_q     <= 1'b0;
        end else begin
            intr_q <= (mtime_q >= mtimecmp_q);

            if (wr && idx == 3'd0) en_q <= wdata[0];

            if (wr && idx == 3'd1) begin
                presc_q <= wdata[PrescaleW-1:0];
                pcnt_q  <= '0;
            end else if (en_q) begin
                pcnt_q  <= tick ? '0 : pcnt_q + 1'b1;
            end

            // A software write to either half overrides the tick; the other
            // half keeps its pre-tick value, so no carry crosses halves.
            if (wr && idx == 3'd2)      mtime_q[31:0]  <= wdata;
            else if (wr && idx == 3'd3) mtime_q[63:32] <= wdata;
            else if (tick)              mtime_q        <= mtime_q + 64'd1;

            if (wr && idx == 3'd4) mtimecmp_q[31:0]  <= wdata;
            if (wr && idx == 3'd5) mtimecmp_q[63:32] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= AccessAck;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else if (acc) begin
            d_valid_q  <= 1'b1;
            d_opcode_q <= is_get ? AccessAckData : AccessAck;
            d_size_q   <= tl_i.a_size;
            d_source_q <= tl_i.a_source;
            d_data_q   <= (is_get && !err) ? rdata : 32'h0;
            d_error_q  <= err;
        end else if (tl_i.d_ready) begin
            d_valid_q  <= 1'b0;
        end
    end

    assign tl_o.d_valid  = d_valid_q;
    assign tl_o.d_opcode = d_opcode_q;
    assign tl_o.d_param  = 3'h0;
    assign tl_o.d_size   = d_size_q;
    assign tl_o.d_source = d_source_q;
    assign tl_o.d_sink   = 1'b0;
    assign tl_o.d_data   = d_data_q;
    assign tl_o.d_error  = d_error_q;
    assign tl_o.a_ready  = !d_valid_q;

    assign intr_timer_o = intr_q;

    logic unused_bits;
    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:12], wdata};

endmodule

// File: tb/tb_rv_timer_tl.sv
// tb_rv_timer_tl -- randomized scoreboard bench for rv_timer_tl.
//
// The driver issues TL-UL requests and steps a behavioural timer model once
// per clock; each accepted request pushes its expected response. A separate
// monitor compares the DUT response channel and interrupt on every falling
// edge against the scoreboard and the model.

module tb_rv_timer_tl;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic    intr;

    always #5 clk = ~clk;

    rv_timer_tl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tl_i         (tl_i),
        .tl_o         (tl_o),
        .intr_timer_o (intr)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   dmode = 1;   // 0 random d_ready, 1 always ready, 2 stalled

    // Reference model state
    logic        m_en, m_intr, m_dvalid, m_acc;
    logic [15:0] m_presc, m_pcnt;
    logic [63:0] m_mtime, m_cmp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_en = 0; m_presc = 0; m_pcnt = 0; m_mtime = 0; m_cmp = '1;
        m_intr = 0; m_dvalid = 0; m_acc = 0;
    endtask

    // Advance the model across the clock edge that just happened, using the
    // inputs that were held during the preceding cycle.
    task automatic model_step();
        logic        tick, is_get, is_put, err, n_en, n_dvalid;
        logic [11:0] off;
        logic [31:0] cur, w;
        logic [15:0] n_pcnt, n_presc;
        logic [63:0] n_mtime, n_cmp;
        exp_t        e;
        m_acc    = tl_i.a_valid && !m_dvalid;
        n_dvalid = m_dvalid && !tl_i.d_ready;
        tick     = m_en && (m_pcnt == m_presc);
        n_pcnt   = !m_en ? m_pcnt : (tick ? 16'd0 : m_pcnt + 16'd1);
        n_mtime  = m_mtime + (tick ? 64'd1 : 64'd0);
        n_cmp    = m_cmp;
        n_presc  = m_presc;
        n_en     = m_en;
        if (m_acc) begin
            off    = tl_i.a_address[11:0];
            is_get = tl_i.a_opcode == Get;
            is_put = tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData;
            err    = off[1:0] != 0 || off >= 12'h1C || !(is_get || is_put)
                   || (is_put && off == 12'h18);
            case (off)
                12'h00:  cur = {31'b0, m_en};
                12'h04:  cur = {16'b0, m_presc};
                12'h08:  cur = m_mtime[31:0];
                12'h0C:  cur = m_mtime[63:32];
                12'h10:  cur = m_cmp[31:0];
                12'h14:  cur = m_cmp[63:32];
                12'h18:  cur = {31'b0, m_intr};
                default: cur = 0;
            endcase
            e.op   = is_get ? AccessAckData : AccessAck;
            e.size = tl_i.a_size;
            e.src  = tl_i.a_source;
            e.err  = err;
            e.data = (is_get && !err) ? cur : 32'h0;
            sb.push_back(e);
            n_dvalid = 1;
            if (is_put && !err) begin
                w = merge(cur, tl_i.a_data, tl_i.a_mask);
                case (off)
                    12'h00: n_en = w[0];
                    12'h04: begin n_presc = w[15:0]; n_pcnt = 0; end
                    12'h08: n_mtime = {m_mtime[63:32], w};
                    12'h0C: n_mtime = {w, m_mtime[31:0]};
                    12'h10: n_cmp[31:0] = w;
                    12'h14: n_cmp[63:32] = w;
                    default: ;
                endcase
            end
        end
        m_intr   = (m_mtime >= m_cmp);
        m_en     = n_en;
        m_presc  = n_presc;
        m_pcnt   = n_pcnt;
        m_mtime  = n_mtime;
        m_cmp    = n_cmp;
        m_dvalid = n_dvalid;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        case (dmode)
            0:       tl_i.d_ready = ($urandom_range(3) != 0);
            2:       tl_i.d_ready = 1'b0;
            default: tl_i.d_ready = 1'b1;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask);
        int n = 0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_param   = 3'h0;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = 8'($urandom);
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        forever begin
            cyc();
            if (m_acc) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        tl_i.a_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        req(Get, addr, 32'h0, 4'hF);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        req(PutFullData, addr, data, 4'hF);
    endtask

    task automatic rd_all();
        for (int a = 0; a <= 'h18; a += 4) rd(a);
    endtask

    // Monitor: response channel against the scoreboard, interrupt against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("intr", intr, m_intr);
            chk("d_valid", tl_o.d_valid, sb.size() != 0);
            chk("a_ready", tl_o.a_ready, sb.size() == 0);
            if (tl_o.d_valid && sb.size() != 0) begin
                chk("d_opcode", tl_o.d_opcode, sb[0].op);
                chk("d_size",   tl_o.d_size,   sb[0].size);
                chk("d_source", tl_o.d_source, sb[0].src);
                chk("d_error",  tl_o.d_error,  sb[0].err);
                chk("d_data",   tl_o.d_data,   sb[0].data);
                chk("d_param",  tl_o.d_param,  3'h0);
                chk("d_sink",   tl_o.d_sink,   1'b0);
                if (tl_i.d_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr, data;
        int          r;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_d_valid", tl_o.d_valid, 1'b0);
        chk("rst_a_ready", tl_o.a_ready, 1'b1);
        chk("rst_intr", intr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        rd_all();

        // Prescaled counting, then hold with EN=0
        wr(32'h04, 32'd3);
        wr(32'h00, 32'd1);
        idle(40);
        rd(32'h08);
        wr(32'h00, 32'd0);
        rd(32'h08);
        idle(20);
        rd(32'h08);

        // 64-bit wrap
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h0C, 32'hFFFF_FFFF);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'd1);
        idle(2);
        rd(32'h08);
        rd(32'h0C);

        // Compare match and clear
        wr(32'h00, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h14, 32'd0);
        wr(32'h10, 32'd100);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'd1);
        idle(110);
        rd(32'h18);
        wr(32'h10, 32'hFFFF_FFFF);
        wr(32'h14, 32'hFFFF_FFFF);
        idle(3);

        // Errors and partial writes
        rd(32'h1C);
        rd(32'h02);
        wr(32'h18, 32'd1);
        req(3'h2, 32'h00, 32'd1, 4'hF);
        wr(32'h00, 32'd0);
        req(PutPartialData, 32'h00, 32'hFFFF_FFFF, 4'h2);
        rd(32'h00);

        // Response stall
        dmode = 2;
        rd(32'h08);
        idle(5);
        dmode = 1;
        idle(2);

        // Randomized traffic with random back-pressure
        dmode = 0;
        repeat (400) begin
            idle($urandom_range(0, 2));
            r    = $urandom_range(0, 9);
            addr = {20'($urandom), 12'($urandom_range(0, 8) * 4)};
            if ($urandom_range(0, 15) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            data = $urandom;
            if (addr[11:0] == 12'h04) data = $urandom_range(0, 5);
            if (r < 5)      op = Get;
            else if (r < 7) op = PutFullData;
            else if (r < 9) op = PutPartialData;
            else            op = 3'($urandom_range(5, 7));
            req(op, addr, data, 4'($urandom));
        end
        dmode = 1;
        idle(5);

        // Reset while a response is pending
        wr(32'h04, 32'd2);
        wr(32'h00, 32'd1);
        dmode = 2;
        rd(32'h08);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("rst_mid_d_valid", tl_o.d_valid, 1'b0);
        chk("rst_mid_a_ready", tl_o.a_ready, 1'b1);
        chk("rst_mid_intr", intr, 1'b0);
        tl_i.d_ready = 1'b1;
        dmode = 1;
        @(negedge clk);
        rst_n = 1'b1;
        rd_all();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
